// File: rtl/im_fetch.sv
// im_fetch: wait-state instruction memory with a valid/ready fetch handshake and a program-load write port
module im_fetch #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_3000,
  parameter int          DEPTH_WORDS = 2048,
  parameter int          WAIT_CYCLES = 1,
  parameter string       INIT_FILE   = "code.txt"
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic        rsp_fault,
  input  logic        flush,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data
);
  localparam int          AW    = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN  = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WLOAD = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d, instr_q;
  logic        fault_q, rd;
  logic [31:0] raddr, roff, woff;
  logic        rfault, wok;
  logic [31:0] mem_q [DEPTH_WORDS];
  initial begin
    for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] = '0;
  end
  assign raddr     = state_q == IDLE ? req_pc : pc_q;
  assign roff      = raddr - BASE_ADDR;
  assign woff      = wr_addr - BASE_ADDR;
  assign rfault    = raddr[1:0] != 2'b00 || roff >= SPAN;
  assign wok       = wr_en && wr_addr[1:0] == 2'b00 && woff < SPAN;
  assign req_ready = state_q == IDLE && !flush && !reset;
  assign rsp_valid = state_q == RESP && !reset;
  assign rsp_instr = instr_q;
  assign rsp_fault = fault_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    rd      = 1'b0;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == IDLE) begin
      if (req_valid) begin
        pc_d    = req_pc;
        cnt_d   = WLOAD;
        state_d = WAIT_CYCLES > 0 ? WAIT : RESP;
        rd      = WAIT_CYCLES == 0;
      end
    end else if (state_q == WAIT) begin
      if (cnt_q == 4'd0) begin
        state_d = RESP;
        rd      = 1'b1;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end else if (rsp_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
      instr_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      if (rd) begin
        instr_q <= rfault ? '0 : mem_q[roff[AW+1:2]];
        fault_q <= rfault;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (wok) mem_q[woff[AW+1:2]] <= wr_data;
  end
endmodule

// File: tb/tb_im_fetch.sv
// tb_im_fetch: random and directed fetch traffic checked against a transaction-level memory model
module tb_im_fetch;
  localparam logic [31:0] BASE  = 32'h0000_3000;
  localparam int          DEPTH = 2048;
  localparam int          WC    = 2;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        reset, req_valid, req_ready, rsp_valid, rsp_ready, rsp_fault, flush, wr_en;
  logic [31:0] req_pc, rsp_instr, wr_addr, wr_data;
  logic        b_reset, b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_fault, b_flush, b_wr_en;
  logic [31:0] b_req_pc, b_rsp_instr, b_wr_addr, b_wr_data;
  im_fetch #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC), .INIT_FILE("")) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr), .rsp_fault(rsp_fault),
    .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));
  im_fetch #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .INIT_FILE("")) dut0 (
    .clk(clk), .reset(b_reset), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_pc(b_req_pc),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_instr(b_rsp_instr), .rsp_fault(b_rsp_fault),
    .flush(b_flush), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data));
  int n_vec = 0;
  int n_err = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // Reference model: one outstanding fetch, a countdown of edges until the answer, and a word array.
  bit [31:0]   m_mem [DEPTH];
  bit          m_busy = 0, m_valid = 0, m_fault = 0, started = 0;
  int          m_left = 0;
  logic [31:0] m_pc = '0, m_instr = '0;
  function automatic bit in_rng(input logic [31:0] a);
    return a >= BASE && a < BASE + 32'(4 * DEPTH);
  endfunction
  task automatic produce();
    m_fault = m_pc[1:0] != 2'b00 || !in_rng(m_pc);
    m_instr = m_fault ? 32'h0 : m_mem[(m_pc - BASE) / 4];
    m_valid = 1;
  endtask
  always @(posedge clk) begin
    if (reset) begin
      m_busy = 0; m_valid = 0; m_instr = '0; m_fault = 0;
    end else if (flush) begin
      m_busy = 0; m_valid = 0;
    end else if (m_valid) begin
      if (rsp_ready) m_valid = 0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        produce();
        m_busy = 0;
      end
    end else if (req_valid) begin
      m_pc = req_pc;
      m_left = WC;
      if (WC == 0) produce(); else m_busy = 1;
    end
    if (wr_en && wr_addr[1:0] == 2'b00 && in_rng(wr_addr)) m_mem[(wr_addr - BASE) / 4] = wr_data;
    if (reset) started = 1;
  end
  // Per-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("req_ready", 32'(req_ready), 32'(!reset && !flush && !m_busy && !m_valid));
      chk("rsp_valid", 32'(rsp_valid), 32'(!reset && m_valid));
      if (!reset && m_valid) begin
        chk("rsp_instr", rsp_instr, m_instr);
        chk("rsp_fault", 32'(rsp_fault), 32'(m_fault));
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic fetch(input logic [31:0] pc, output logic [31:0] ins, output logic flt, output int lat);
    req_valid = 1; req_pc = pc;
    tick();
    req_valid = 0; lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    if (!rsp_valid) chk("fetch_timeout", 32'(rsp_valid), 32'd1);
    ins = rsp_instr; flt = rsp_fault;
  endtask
  task automatic take();
    tick();
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 0;
  endtask
  logic [31:0] ins;
  logic        flt;
  int          lat, nr, last, r;
  logic        acc;
  logic [31:0] bad_pc [3];
  initial begin
    bad_pc[0] = 32'h3002; bad_pc[1] = 32'h2FFC; bad_pc[2] = 32'h5000;
    reset = 1; req_valid = 0; req_pc = '0; rsp_ready = 0; flush = 0; wr_en = 0; wr_addr = '0; wr_data = '0;
    b_reset = 1; b_req_valid = 0; b_req_pc = '0; b_rsp_ready = 0; b_flush = 0; b_wr_en = 0; b_wr_addr = '0; b_wr_data = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_instr", rsp_instr, 32'd0);
    tick();
    reset = 0;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    tick();
    wr(32'h3000, 32'h2008_0005);
    chk("model_word0", m_mem[0], 32'h2008_0005);
    fetch(32'h3000, ins, flt, lat);
    chk("latency", 32'(lat), 32'(WC + 1));
    chk("word0_instr", ins, 32'h2008_0005);
    chk("word0_fault", 32'(flt), 32'd0);
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_ready", 32'(req_ready), 32'd0);
      chk("hold_instr", rsp_instr, 32'h2008_0005);
    end
    take();
    @(negedge clk);
    chk("back_idle_valid", 32'(rsp_valid), 32'd0);
    chk("back_idle_ready", 32'(req_ready), 32'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      fetch(bad_pc[i], ins, flt, lat);
      chk("bad_fault", 32'(flt), 32'd1);
      chk("bad_instr", ins, 32'd0);
      take();
    end
    wr(32'h3004, 32'h1111_2222);
    req_valid = 1; req_pc = 32'h3004;
    tick();
    req_valid = 0;
    tick();
    wr(32'h3004, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("rbw_valid", 32'(rsp_valid), 32'd1);
    chk("rbw_old", rsp_instr, 32'h1111_2222);
    take();
    fetch(32'h3004, ins, flt, lat);
    chk("rbw_new", ins, 32'hDEAD_BEEF);
    take();
    wr(32'h5000, 32'h5555_5555);
    wr(32'h3005, 32'h6666_6666);
    fetch(32'h3004, ins, flt, lat);
    chk("ignored_wr", ins, 32'hDEAD_BEEF);
    take();
    wr(32'h3000 + 32'(4 * DEPTH - 4), 32'h7777_0001);
    fetch(32'h3000 + 32'(4 * DEPTH - 4), ins, flt, lat);
    chk("last_word", ins, 32'h7777_0001);
    chk("last_fault", 32'(flt), 32'd0);
    take();
    req_valid = 1; req_pc = 32'h3000;
    tick();
    req_valid = 0; flush = 1;
    tick();
    flush = 0;
    repeat (6) begin
      @(negedge clk);
      chk("flush_wait_valid", 32'(rsp_valid), 32'd0);
    end
    tick();
    req_valid = 1; flush = 1;
    @(negedge clk);
    chk("flush_idle_ready", 32'(req_ready), 32'd0);
    tick();
    req_valid = 0; flush = 0;
    repeat (5) begin
      @(negedge clk);
      chk("flush_idle_valid", 32'(rsp_valid), 32'd0);
    end
    tick();
    fetch(32'h3000, ins, flt, lat);
    tick();
    reset = 1;
    tick();
    reset = 0;
    @(negedge clk);
    chk("rst_resp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_resp_ready", 32'(req_ready), 32'd1);
    tick();
    for (int i = 0; i < 800; i++) begin
      r = int'($urandom_range(0, 9));
      req_valid = $urandom_range(0, 1) == 1;
      req_pc = r < 6 ? BASE + 32'(4 * $urandom_range(0, 15)) :
               r == 6 ? BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3)) :
               r == 7 ? BASE - 32'(4 * $urandom_range(1, 4)) :
               r == 8 ? BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3)) :
               BASE + 32'(4 * DEPTH - 4);
      rsp_ready = $urandom_range(0, 1) == 1;
      flush = $urandom_range(0, 19) == 0;
      reset = $urandom_range(0, 49) == 0;
      wr_en = $urandom_range(0, 2) == 0;
      wr_addr = $urandom_range(0, 7) == 0 ? 32'h5000 + 32'($urandom_range(0, 3)) : BASE + 32'(4 * $urandom_range(0, 15));
      wr_data = $urandom;
      tick();
    end
    reset = 0; req_valid = 0; rsp_ready = 0; flush = 0; wr_en = 0;
    tick();
    b_reset = 0;
    for (int k = 0; k < 8; k++) begin
      b_wr_en = 1; b_wr_addr = BASE + 32'(4 * k); b_wr_data = 32'hA500_0000 + 32'(k * 32'h111);
      tick();
    end
    b_wr_en = 0; b_req_valid = 1; b_rsp_ready = 1; b_req_pc = BASE;
    nr = 0; last = -10;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      acc = b_req_ready;
      if (b_rsp_valid) begin
        chk("b2b_order", b_rsp_instr, 32'hA500_0000 + 32'(nr * 32'h111));
        if (nr > 0) chk("b2b_gap", 32'(c - last), 32'd2);
        last = c;
        nr++;
      end
      tick();
      if (acc) b_req_pc = b_req_pc + 32'd4;
    end
    chk("b2b_count", 32'(nr), 32'd8);
    b_req_valid = 0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
